// File: rtl/key_entry_if.sv
// Scanner-to-calculator key path: decoded key inputs in, BCD operand and command strobes out.
interface key_entry_if #(
    parameter int DIGITS = 4
);
    logic                  key_valid;
    logic [3:0]            key;
    logic                  keytype;
    logic [4*DIGITS-1:0]   operand;
    logic [2:0]            digit_count;
    logic [1:0]            op_code;
    logic                  op_strobe;
    logic                  equals_strobe;
    logic                  clear_strobe;
    logic                  overflow;

    modport master (
        output key_valid, key, keytype,
        input  operand, digit_count, op_code,
        input  op_strobe, equals_strobe, clear_strobe, overflow
    );

    modport slave (
        input  key_valid, key, keytype,
        output operand, digit_count, op_code,
        output op_strobe, equals_strobe, clear_strobe, overflow
    );
endinterface

// File: rtl/key_entry.sv
// Converts each debounced keypad press into one event: digits build a BCD operand,
// symbol keys raise one-cycle strobes for the calculator core.
module key_entry #(
    parameter int DIGITS         = 4,
    parameter int RELEASE_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    key_entry_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(RELEASE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        HELD,
        RELEASE
    } state_t;

    state_t          state;
    logic [CW-1:0]   rel_count;
    logic [W-1:0]    operand_q;
    logic [2:0]      count_q;
    logic [1:0]      op_code_q;
    logic            op_strobe_q;
    logic            equals_strobe_q;
    logic            clear_strobe_q;
    logic            overflow_q;

    // Reset lands in RELEASE with an empty counter, so a key held through reset is never taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= RELEASE;
            rel_count       <= '0;
            operand_q       <= '0;
            count_q         <= '0;
            op_code_q       <= '0;
            op_strobe_q     <= 1'b0;
            equals_strobe_q <= 1'b0;
            clear_strobe_q  <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            op_strobe_q     <= 1'b0;
            equals_strobe_q <= 1'b0;
            clear_strobe_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.key_valid) begin
                        if (bus.keytype && (bus.key <= 4'd9)) begin
                            if (count_q == 3'(DIGITS)) begin
                                overflow_q <= 1'b1;
                            end else begin
                                operand_q <= (operand_q << 4) | W'(bus.key);
                                count_q   <= count_q + 3'd1;
                            end
                            state <= EMIT;
                        end else if (!bus.keytype && (bus.key >= 4'hA)) begin
                            case (bus.key)
                                4'hE:    equals_strobe_q <= 1'b1;
                                4'hF:    clear_strobe_q  <= 1'b1;
                                default: begin
                                    op_code_q   <= 2'(bus.key - 4'hA);
                                    op_strobe_q <= 1'b1;
                                end
                            endcase
                            state <= EMIT;
                        end else begin
                            state <= HELD;
                        end
                    end
                end
                EMIT: begin
                    // The core samples the operand alongside the strobe, so it is only cleared on exit.
                    if (op_strobe_q || equals_strobe_q || clear_strobe_q) begin
                        operand_q  <= '0;
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                    end
                    state <= HELD;
                end
                HELD: begin
                    if (!bus.key_valid) begin
                        rel_count <= CW'(1);
                        state     <= (RELEASE_CYCLES <= 1) ? IDLE : RELEASE;
                    end
                end
                RELEASE: begin
                    if (bus.key_valid) begin
                        rel_count <= '0;
                        state     <= HELD;
                    end else begin
                        if (rel_count != CW'(RELEASE_CYCLES)) begin
                            rel_count <= rel_count + CW'(1);
                        end
                        if ((int'(rel_count) + 1) >= RELEASE_CYCLES) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= RELEASE;
            endcase
        end
    end

    assign bus.operand       = operand_q;
    assign bus.digit_count   = count_q;
    assign bus.op_code       = op_code_q;
    assign bus.op_strobe     = op_strobe_q;
    assign bus.equals_strobe = equals_strobe_q;
    assign bus.clear_strobe  = clear_strobe_q;
    assign bus.overflow      = overflow_q;

    strobes_exclusive: assert property (@(posedge clock) disable iff (reset)
        $onehot0({op_strobe_q, equals_strobe_q, clear_strobe_q}));
endmodule

// File: tb/tb_key_entry.sv
// Directed presses push expected output snapshots into a queue; a monitor pops one
// whenever the visible outputs change and checks both value and cycle.
module tb_key_entry;
    localparam int DIGITS = 4;
    localparam int RC     = 16;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    key_entry_if #(.DIGITS(DIGITS)) bus ();

    key_entry #(
        .DIGITS(DIGITS),
        .RELEASE_CYCLES(RC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [15:0] operand;
        logic [2:0]  count;
        logic [1:0]  op;
        logic [2:0]  strobes;
        logic        ovf;
        int          cyc;
    } obs_t;

    obs_t exp_q[$];
    obs_t prev;
    obs_t cur;
    obs_t expd;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic obs_t sample();
        obs_t s;
        s.operand = bus.operand;
        s.count   = bus.digit_count;
        s.op      = bus.op_code;
        s.strobes = {bus.op_strobe, bus.equals_strobe, bus.clear_strobe};
        s.ovf     = bus.overflow;
        s.cyc     = cyc;
        return s;
    endfunction

    function automatic bit same(obs_t a, obs_t b);
        return (a.operand === b.operand) && (a.count === b.count) && (a.op === b.op)
            && (a.strobes === b.strobes) && (a.ovf === b.ovf);
    endfunction

    function automatic obs_t make(logic [15:0] opnd, logic [2:0] cnt, logic [1:0] op,
                                  logic [2:0] stb, logic ovf, int c);
        obs_t s;
        s.operand = opnd;
        s.count   = cnt;
        s.op      = op;
        s.strobes = stb;
        s.ovf     = ovf;
        s.cyc     = c;
        return s;
    endfunction

    // Every change of the visible outputs must match the next queued expectation, in the predicted cycle.
    always @(negedge clock) begin
        if (mon_en) begin
            cur = sample();
            if (!same(cur, prev)) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("[TB] FAIL unexpected_change cyc=%0d got opnd=%h cnt=%0d op=%b stb=%b ovf=%b, required no change",
                             cur.cyc, cur.operand, cur.count, cur.op, cur.strobes, cur.ovf);
                end else begin
                    expd = exp_q.pop_front();
                    if (!same(cur, expd) || (cur.cyc != expd.cyc)) begin
                        n_err++;
                        $display("[TB] FAIL event cyc=%0d got opnd=%h cnt=%0d op=%b stb=%b ovf=%b, required cyc=%0d opnd=%h cnt=%0d op=%b stb=%b ovf=%b",
                                 cur.cyc, cur.operand, cur.count, cur.op, cur.strobes, cur.ovf,
                                 expd.cyc, expd.operand, expd.count, expd.op, expd.strobes, expd.ovf);
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic wait_cycles(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_exp(logic [15:0] opnd, logic [2:0] cnt, logic [1:0] op,
                            logic [2:0] stb, logic ovf, int c);
        exp_q.push_back(make(opnd, cnt, op, stb, ovf, c));
    endtask

    // One press: hold for 'hold' cycles, then release for 'rel' cycles. Symbol events also expect the clear.
    task automatic apply_stimulus(logic [3:0] k, logic kt, int hold, int rel, bit ev,
                                  logic [15:0] opnd, logic [2:0] cnt, logic [1:0] op,
                                  logic [2:0] stb, logic ovf);
        bus.key       = k;
        bus.keytype   = kt;
        bus.key_valid = 1'b1;
        if (ev) begin
            push_exp(opnd, cnt, op, stb, ovf, cyc + 1);
            if (stb != 3'b000) push_exp(16'h0000, 3'd0, op, 3'b000, 1'b0, cyc + 2);
        end
        wait_cycles(hold);
        bus.key_valid = 1'b0;
        wait_cycles(rel);
    endtask

    task automatic check_output(string name, obs_t want);
        obs_t got;
        got = sample();
        n_vec++;
        if (!same(got, want)) begin
            n_err++;
            $display("[TB] FAIL %s got opnd=%h cnt=%0d op=%b stb=%b ovf=%b, required opnd=%h cnt=%0d op=%b stb=%b ovf=%b",
                     name, got.operand, got.count, got.op, got.strobes, got.ovf,
                     want.operand, want.count, want.op, want.strobes, want.ovf);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.key_valid = 1'b1;
        bus.key       = 4'h5;
        bus.keytype   = 1'b1;
        wait_cycles(3);
        check_output("reset_state", make(16'h0000, 3'd0, 2'b00, 3'b000, 1'b0, 0));
        prev   = make(16'h0000, 3'd0, 2'b00, 3'b000, 1'b0, 0);
        mon_en = 1'b1;
        reset  = 1'b0;

        // Key held through and past reset, then exactly RC low cycles before the next press.
        wait_cycles(37);
        bus.key_valid = 1'b0;
        wait_cycles(RC);
        apply_stimulus(4'h5, 1'b1, 5, 20, 1'b1, 16'h0005, 3'd1, 2'b00, 3'b000, 1'b0);
        apply_stimulus(4'hF, 1'b0, 5, 20, 1'b1, 16'h0005, 3'd1, 2'b00, 3'b001, 1'b0);

        // Fill the operand, then overflow.
        apply_stimulus(4'h1, 1'b1, 5, 20, 1'b1, 16'h0001, 3'd1, 2'b00, 3'b000, 1'b0);
        apply_stimulus(4'h2, 1'b1, 5, 20, 1'b1, 16'h0012, 3'd2, 2'b00, 3'b000, 1'b0);
        apply_stimulus(4'h3, 1'b1, 5, 20, 1'b1, 16'h0123, 3'd3, 2'b00, 3'b000, 1'b0);
        apply_stimulus(4'h4, 1'b1, 5, 20, 1'b1, 16'h1234, 3'd4, 2'b00, 3'b000, 1'b0);
        apply_stimulus(4'h9, 1'b1, 5, 20, 1'b1, 16'h1234, 3'd4, 2'b00, 3'b000, 1'b1);
        apply_stimulus(4'h9, 1'b1, 5, 20, 1'b0, 16'h0000, 3'd0, 2'b00, 3'b000, 1'b0);
        apply_stimulus(4'hA, 1'b0, 5, 20, 1'b1, 16'h1234, 3'd4, 2'b00, 3'b100, 1'b1);

        // Operator with a partial operand.
        apply_stimulus(4'h4, 1'b1, 5, 20, 1'b1, 16'h0004, 3'd1, 2'b00, 3'b000, 1'b0);
        apply_stimulus(4'h2, 1'b1, 5, 20, 1'b1, 16'h0042, 3'd2, 2'b00, 3'b000, 1'b0);
        apply_stimulus(4'hB, 1'b0, 5, 20, 1'b1, 16'h0042, 3'd2, 2'b01, 3'b100, 1'b0);

        // Bounce after 5 low cycles, then a press after only RC-1 low cycles, both rejected.
        apply_stimulus(4'h7, 1'b1, 5, 5,  1'b1, 16'h0007, 3'd1, 2'b01, 3'b000, 1'b0);
        apply_stimulus(4'h7, 1'b1, 3, RC - 1, 1'b0, 16'h0000, 3'd0, 2'b00, 3'b000, 1'b0);
        apply_stimulus(4'h6, 1'b1, 3, RC, 1'b0, 16'h0000, 3'd0, 2'b00, 3'b000, 1'b0);
        apply_stimulus(4'h6, 1'b1, 5, 20, 1'b1, 16'h0076, 3'd2, 2'b01, 3'b000, 1'b0);

        // Inconsistent key/keytype pairs produce nothing.
        apply_stimulus(4'h5, 1'b0, 3, RC, 1'b0, 16'h0000, 3'd0, 2'b00, 3'b000, 1'b0);
        apply_stimulus(4'hA, 1'b1, 3, RC, 1'b0, 16'h0000, 3'd0, 2'b00, 3'b000, 1'b0);

        apply_stimulus(4'hE, 1'b0, 5, 20, 1'b1, 16'h0076, 3'd2, 2'b01, 3'b010, 1'b0);
        apply_stimulus(4'hF, 1'b0, 5, 20, 1'b1, 16'h0000, 3'd0, 2'b01, 3'b001, 1'b0);

        // Key code changes while held: only the first code counts.
        bus.key       = 4'h1;
        bus.keytype   = 1'b1;
        bus.key_valid = 1'b1;
        push_exp(16'h0001, 3'd1, 2'b01, 3'b000, 1'b0, cyc + 1);
        wait_cycles(2);
        bus.key = 4'h2;
        wait_cycles(3);
        bus.key_valid = 1'b0;
        wait_cycles(20);

        apply_stimulus(4'hC, 1'b0, 5, 20, 1'b1, 16'h0001, 3'd1, 2'b10, 3'b100, 1'b0);
        apply_stimulus(4'hD, 1'b0, 5, 20, 1'b1, 16'h0000, 3'd0, 2'b11, 3'b100, 1'b0);

        // Reset during the EMIT cycle of digit 3.
        bus.key       = 4'h3;
        bus.keytype   = 1'b1;
        bus.key_valid = 1'b1;
        push_exp(16'h0003, 3'd1, 2'b11, 3'b000, 1'b0, cyc + 1);
        push_exp(16'h0000, 3'd0, 2'b00, 3'b000, 1'b0, cyc + 2);
        wait_cycles(1);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        wait_cycles(3);
        bus.key_valid = 1'b0;
        wait_cycles(RC - 1);
        apply_stimulus(4'h8, 1'b1, 3, RC, 1'b0, 16'h0000, 3'd0, 2'b00, 3'b000, 1'b0);
        apply_stimulus(4'h8, 1'b1, 5, 20, 1'b1, 16'h0008, 3'd1, 2'b00, 3'b000, 1'b0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clock);
        while (exp_q.size() != 0) begin
            expd = exp_q.pop_front();
            n_vec++;
            n_err++;
            $display("[TB] FAIL missing_event got no change, required cyc=%0d opnd=%h cnt=%0d op=%b stb=%b ovf=%b",
                     expd.cyc, expd.operand, expd.count, expd.op, expd.strobes, expd.ovf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/key_entry.md
Name: key_entry

Overview:
- Sits directly downstream of the keypad scanner and consumes its decoded `key`/`keytype` plus a press-valid level.
- Turns each physical press into exactly one event, with release hold-off.
- Digit presses accumulate into a BCD operand of up to DIGITS digits.
- Operator, equals and clear keys produce single-cycle strobes for the calculator core.

Parameters:
- DIGITS, 4, maximum BCD digits held in operand (1..7).
- RELEASE_CYCLES, 16, consecutive cycles with key_valid low required before the next press is accepted (>=1).

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- key_valid  in  1  level, high while the scanner reports a pressed key
- key  in  4  scanner key code: 0-9 digits, A=0xA, B=0xB, C=0xC, D=0xD, #=0xE, *=0xF
- keytype  in  1  1 = digit key (code <= 9), 0 = symbol key
- operand  out  4*DIGITS  BCD operand; most recent digit in bits [3:0]
- digit_count  out  3  digits currently held, 0..DIGITS
- op_code  out  2  last operator: A->00 add, B->01 sub, C->10 mul, D->11 div
- op_strobe  out  1  one-cycle pulse on operator key
- equals_strobe  out  1  one-cycle pulse on # key
- clear_strobe  out  1  one-cycle pulse on * key
- overflow  out  1  sticky; a digit arrived while digit_count == DIGITS

Behaviour:
- Reset values:
  - operand = 0, digit_count = 0, op_code = 00.
  - All strobes = 0, overflow = 0.
  - State = RELEASE with release counter = 0.
  - A key held through reset is therefore never accepted.
- States: IDLE, EMIT, HELD, RELEASE.
- IDLE: when key_valid = 1, sample key/keytype and go to EMIT.
  - Digit event: keytype = 1 and key <= 9.
  - Symbol event: keytype = 0 and key >= 0xA.
  - Inconsistent key/keytype pair: no event; go straight to HELD.
- EMIT lasts exactly one cycle. Register updates become visible in EMIT, i.e. one cycle after the accepting edge.
  - Digit, count < DIGITS: operand <= {operand shifted left 4, key}; count +1.
  - Digit, count == DIGITS: operand and count unchanged; overflow <= 1.
  - A–D: op_code updated; op_strobe = 1.
  - #: equals_strobe = 1.
  - *: clear_strobe = 1.
  - During EMIT the operand and digit_count hold their pre-clear values so the core can sample them with the strobe.
- EMIT exit: after any symbol event, operand, digit_count and overflow clear to 0 at the EMIT->HELD edge. op_code is retained. Then go to HELD.
- HELD: stay while key_valid = 1. On key_valid = 0, go to RELEASE with counter = 1.
- RELEASE:
  - key_valid = 0: counter +1.
  - Counter reaching RELEASE_CYCLES: go to IDLE.
  - key_valid = 1 before that: back to HELD, counter reset, no event (bounce rejection).
- Only one strobe can be high in any cycle. Strobes are 0 outside EMIT.
- Key code changing while held: ignored; one event per press.
- Reset asserted mid-EMIT: takes priority. Strobes drop and all registers return to reset values on that edge.
- Counter width: $clog2(RELEASE_CYCLES+1). It saturates and does not wrap.

Test Plan:
- Reset with key_valid = 1 held for 40 cycles, then release for 16 cycles -> no strobe, operand = 0; the next press of 5 is accepted, operand = 0x0005, count = 1.
- Press 1,2,3,4 (each held 5 cycles, released 20) -> operand = 0x1234, count = 4.
  - Then press 9 -> operand still 0x1234, overflow = 1.
- With operand = 0x0042, press B -> op_strobe high exactly 1 cycle with operand = 0x0042, op_code = 01.
  - The next cycle: operand = 0, count = 0, overflow = 0.
- Press 7, release 5 cycles, reassert key_valid for 3 cycles (bounce), release 16 cycles -> a single digit event, operand = 0x0007.
- Press # then * -> equals_strobe one pulse, then clear_strobe one pulse; never both in one cycle; op_code unchanged.
- Assert reset during the EMIT cycle of digit 3 -> no strobe, operand = 0, state RELEASE; no event until 16 low cycles have elapsed.
